// File: rtl/alu_serial_seq_pkg.sv
// Shared opcode constants and sequencer state encoding for the bit-serial ALU.
package alu_serial_seq_pkg;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_AND = 2'b10;
  localparam logic [1:0] ALU_OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ADD and SUB are the only ops whose carry/overflow flags are meaningful.
  function automatic logic op_is_arith(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: full adder with B inversion for SUB, plus AND/OR.
module alu_bit_slice
  import alu_serial_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       res,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    b_eff = b ^ (op == ALU_OP_SUB);
    // The adder carry is produced for every op; the sequencer decides whether it matters.
    cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
    case (op)
      ALU_OP_ADD, ALU_OP_SUB: res = a ^ b_eff ^ cin;
      ALU_OP_AND:             res = a & b;
      default:                res = a | b;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial WIDTH-bit ALU sequencer: accepts an op, runs one slice LSB-first for
// WIDTH cycles with a carry flop, then holds result and flags until consumed.
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             ovf_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [1:0]       op_q;
  logic             accept, last_bit, in_shift;
  logic             slice_res, slice_cout;

  assign accept   = in_valid && (state_q == ST_IDLE);
  assign in_shift = (state_q == ST_SHIFT);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  alu_bit_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .res  (slice_res),
    .cout (slice_cout)
  );

  // ---- control: state, bit counter, carry ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= '0;
        carry_q <= in_op[0];
      end else if (in_shift) begin
        cnt_q   <= cnt_q + CNT_W'(1);
        carry_q <= slice_cout;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)  state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit)  state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // ---- datapath: operand shifters, result shifter, overflow capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= in_a;
      b_q  <= in_b;
      op_q <= in_op;
    end else if (in_shift) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      res_q <= {slice_res, res_q[WIDTH-1:1]};
      // carry_q is the carry into the MSB while the last bit is processed
      if (last_bit) ovf_q <= carry_q ^ slice_cout;
    end
  end

  // ---- outputs: gated by DONE so a partial or stale result is never visible ----
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    out_res   = out_valid ? res_q : '0;
    out_carry = out_valid && op_is_arith(op_q) && carry_q;
    out_ovf   = out_valid && op_is_arith(op_q) && ovf_q;
    out_zero  = out_valid && (res_q == '0);
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: directed cases, backpressure, mid-op reset, random ops.
module tb_alu_serial_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [1:0]       in_op = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_res;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             z;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t           e;
    logic [WIDTH:0] s;
    e = '0;
    s = '0;
    case (op)
      2'b00: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[WIDTH-1:0];
        e.c   = s[WIDTH];
        e.v   = (a[WIDTH-1] == b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        s     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        e.res = s[WIDTH-1:0];
        e.c   = s[WIDTH];
        e.v   = (a[WIDTH-1] != b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10:   e.res = a & b;
      default: e.res = a | b;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int bp);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    sb.push_back(model(op, a, b));
    #1;
    in_valid = 1'b0;
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
    in_op    = 2'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(WIDTH));
    e = sb.pop_front();
    for (int i = 0; i < bp; i++) begin
      check("bp_res", 32'(out_res), 32'(e.res));
      check("bp_flags", {29'd0, out_carry, out_ovf, out_zero}, {29'd0, e.c, e.v, e.z});
      check("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = ~in_valid;
      in_a     = 8'h11;
      in_b     = 8'h22;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("out_valid", 32'(out_valid), 32'd1);
    check("res", 32'(out_res), 32'(e.res));
    check("carry", 32'(out_carry), 32'(e.c));
    check("ovf", 32'(out_ovf), 32'(e.v));
    check("zero", 32'(out_zero), 32'(e.z));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
    if (bp > 0) begin
      repeat (3) @(posedge clk);
      #1;
      check("no_stray_accept", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_res"}, 32'(out_res), 32'd0);
    check({tag, "_flags"}, {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 8'h7F, 8'h01, 0);
    run_op(2'b01, 8'h05, 8'h05, 0);
    run_op(2'b01, 8'h03, 8'h05, 0);
    run_op(2'b10, 8'hF0, 8'h3C, 0);
    run_op(2'b11, 8'hF0, 8'h3C, 0);
    run_op(2'b00, 8'hFF, 8'h01, 0);
    run_op(2'b00, 8'h80, 8'h80, 0);
    run_op(2'b01, 8'h80, 8'h01, 5);

    // Abort in the fourth SHIFT cycle
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_a     = 8'h55;
    in_b     = 8'h0F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 8'h01, 8'h02, 0);

    for (int k = 0; k < 16; k++)
      run_op(2'($urandom), WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 2)));

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
